// File: rtl/pe_drain_if.sv
// Row output stream of pe_drain: show-ahead valid/ready with tile framing.
interface pe_drain_if #(
  parameter int COLS   = 4,
  parameter int MUL_BW = 16
);
  logic                   out_vld;
  logic                   out_rdy;
  logic [COLS*MUL_BW-1:0] out_data;
  logic                   out_last;

  modport master (
    output out_vld, out_data, out_last,
    input  out_rdy
  );

  modport slave (
    input  out_vld, out_data, out_last,
    output out_rdy
  );
endinterface

// File: rtl/pe_drain.sv
// PE array drain: de-skews column partial sums, rescales/saturates to
// Q INT_BW.FRA_BW and buffers rows in a show-ahead FIFO with tile framing.
module pe_drain #(
  parameter int INT_BW     = 5,
  parameter int FRA_BW     = 10,
  parameter int MUL_BW     = 16,
  parameter int ACC_BW     = 32,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            cfg_rows,
  input  logic                   in_vld,
  input  logic [COLS*ACC_BW-1:0] o_i,
  pe_drain_if.master             ob,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = COLS * MUL_BW;
  localparam logic signed [ACC_BW-1:0] SMAX =
    {{(ACC_BW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SMIN =
    {{(ACC_BW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH
  } st_t;

  st_t         st_q, st_d;
  logic [15:0] rows_q, rows_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        acc, tag_last;

  logic          dv, dl, dly_any;
  logic [RW-1:0] sat_row;
  logic          sv_q, sl_q;
  logic [RW-1:0] sd_q;

  logic [RW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          pop, full, wr, drop;
  logic [RW:0]   head;

  function automatic logic [MUL_BW-1:0] sat_f(input logic [ACC_BW-1:0] a);
    logic signed [ACC_BW-1:0] s;
    s = $signed(a) >>> FRA_BW;
    if (s > SMAX)      return SMAX[MUL_BW-1:0];
    else if (s < SMIN) return SMIN[MUL_BW-1:0];
    else               return s[MUL_BW-1:0];
  endfunction

  // valid/last travel COLS-1 cycles so they line up with the last column
  generate
    if (COLS == 1) begin : g_nv
      assign dv      = acc;
      assign dl      = tag_last;
      assign dly_any = 1'b0;
    end else begin : g_v
      logic [COLS-2:0] v_q, l_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
          l_q <= '0;
        end else begin
          v_q[0] <= acc;
          l_q[0] <= tag_last;
          for (int k = 1; k < COLS - 1; k++) begin
            v_q[k] <= v_q[k-1];
            l_q[k] <= l_q[k-1];
          end
        end
      end
      assign dv      = v_q[COLS-2];
      assign dl      = l_q[COLS-2];
      assign dly_any = |v_q;
    end
  endgenerate

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int D = COLS - 1 - c;
      logic [ACC_BW-1:0] x;
      if (D == 0) begin : g_nd
        assign x = o_i[c*ACC_BW +: ACC_BW];
      end else begin : g_d
        logic [ACC_BW-1:0] sr_q [D];
        always_ff @(posedge clk) begin
          sr_q[0] <= o_i[c*ACC_BW +: ACC_BW];
          for (int k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
        end
        assign x = sr_q[D-1];
      end
      assign sat_row[c*MUL_BW +: MUL_BW] = sat_f(x);
    end
  endgenerate

  assign pop  = ob.out_vld & ob.out_rdy;
  assign full = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign wr   = sv_q & (~full | pop);
  assign drop = sv_q & full & ~pop;
  assign head = mem[rp_q];

  assign ob.out_vld  = (fcnt_q != '0);
  assign ob.out_data = ob.out_vld ? head[RW-1:0] : '0;
  assign ob.out_last = ob.out_vld & head[RW];

  always_comb begin
    fcnt_d = fcnt_q;
    unique case ({wr, pop})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    rows_d   = rows_q;
    rcnt_d   = rcnt_q;
    ovf_d    = ovf_q | drop;
    done_d   = 1'b0;
    acc      = 1'b0;
    tag_last = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          rows_d = cfg_rows;
          rcnt_d = '0;
          ovf_d  = 1'b0;
          st_d   = (cfg_rows == '0) ? S_FLUSH : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (in_vld) begin
          acc      = 1'b1;
          tag_last = (rcnt_q == rows_q - 16'd1);
          rcnt_d   = rcnt_q + 16'd1;
          if (tag_last) st_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!dly_any && !sv_q && !ob.out_vld) begin
          st_d   = S_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      rows_q <= '0;
      rcnt_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      sv_q   <= 1'b0;
      sl_q   <= 1'b0;
      sd_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      rows_q <= rows_d;
      rcnt_q <= rcnt_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      sv_q   <= dv;
      sl_q   <= dl;
      sd_q   <= sat_row;
      fcnt_q <= fcnt_d;
      if (wr)  wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= {sl_q, sd_q};
  end

  assign busy = (st_q != S_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pe_drain.sv
// Directed bench for pe_drain: latency, saturation, backpressure,
// full-with-pop, framing, zero-row tile and mid-tile reset.
module tb_pe_drain;
  localparam int COLS   = 4;
  localparam int ACC_BW = 32;
  localparam int MUL_BW = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [15:0]            cfg_rows = '0;
  logic                   in_vld = 1'b0;
  logic [COLS*ACC_BW-1:0] o_i = '0;
  logic                   busy, done, ovf;

  pe_drain_if #(.COLS(COLS), .MUL_BW(MUL_BW)) ob ();

  pe_drain dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_rows (cfg_rows),
    .in_vld   (in_vld),
    .o_i      (o_i),
    .ob       (ob),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] pd [$];
  bit          pl [$];
  int          pc [$];
  int          done_n = 0;
  int          done_cyc = 0;
  bit          done_busy = 1'b1;
  logic [127:0] hist [COLS];

  always @(negedge clk) begin
    if (!rst && ob.out_vld && ob.out_rdy) begin
      pd.push_back(ob.out_data);
      pl.push_back(ob.out_last);
      pc.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [63:0] qd(input int i);
    return (i < pd.size()) ? pd[i] : 64'bx;
  endfunction

  function automatic logic [63:0] ql(input int i);
    return (i < pl.size()) ? 64'(pl[i]) : 64'bx;
  endfunction

  function automatic int qc(input int i);
    return (i < pc.size()) ? pc[i] : -1000;
  endfunction

  function automatic logic [127:0] mkrow(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // row r column c carries (16r+c) in Q.10, so it drains as 16r+c
  function automatic logic [127:0] rrow(input int r);
    logic [127:0] v;
    for (int c = 0; c < COLS; c++) v[c*32 +: 32] = 32'((r * 16 + c) * 1024);
    return v;
  endfunction

  function automatic logic [63:0] erow(input int r);
    logic [63:0] v;
    for (int c = 0; c < COLS; c++) v[c*16 +: 16] = 16'(r * 16 + c);
    return v;
  endfunction

  task automatic go(input bit v, input logic [127:0] row);
    @(posedge clk);
    #1;
    start  = 1'b0;
    in_vld = v;
    for (int k = COLS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v ? row : '0;
    for (int c = 0; c < COLS; c++) o_i[c*32 +: 32] = hist[c][c*32 +: 32];
  endtask

  task automatic wait_done(input string tag, input int n);
    int d0;
    int i;
    d0 = done_n;
    i  = 0;
    while (done_n == d0 && i < n) begin
      go(1'b0, '0);
      i++;
    end
    chk(tag, 64'(done_n - d0), 64'd1);
  endtask

  task automatic clrq();
    pd.delete();
    pl.delete();
    pc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int d0;
    int nl;
    for (int k = 0; k < COLS; k++) hist[k] = '0;
    ob.out_rdy = 1'b1;
    repeat (3) go(1'b0, '0);
    @(negedge clk);
    chk("rst_vld",  64'(ob.out_vld),  64'd0);
    chk("rst_last", 64'(ob.out_last), 64'd0);
    chk("rst_data", ob.out_data,      64'd0);
    chk("rst_busy", 64'(busy),        64'd0);
    chk("rst_done", 64'(done),        64'd0);
    chk("rst_ovf",  64'(ovf),         64'd0);
    go(1'b0, '0);
    rst = 1'b0;

    // single row, latency and unit values
    go(1'b0, '0);
    start = 1'b1; cfg_rows = 16'd1;
    go(1'b1, mkrow(32'h400, 32'h800, 32'hC00, 32'h1000));
    t0 = cyc;
    wait_done("t1_done", 40);
    chk("t1_n",    64'(pd.size()), 64'd1);
    chk("t1_lat",  64'(qc(0) - t0), 64'd5);
    chk("t1_data", qd(0), 64'h0004_0003_0002_0001);
    chk("t1_last", ql(0), 64'd1);
    chk("t1_busy", 64'(done_busy), 64'd0);

    // saturation and floor rounding
    clrq();
    go(1'b0, '0);
    start = 1'b1; cfg_rows = 16'd2;
    go(1'b1, mkrow(32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000BFF));
    go(1'b1, mkrow(32'h000003FF, 32'hFFFFFC00, 32'h00000400, 32'h0));
    wait_done("t2_done", 40);
    chk("t2_n",     64'(pd.size()), 64'd2);
    chk("t2_d0",    qd(0), 64'h0002_FFFF_8000_7FFF);
    chk("t2_d1",    qd(1), 64'h0000_0001_FFFF_0000);
    chk("t2_last0", ql(0), 64'd0);
    chk("t2_last1", ql(1), 64'd1);

    // backpressure: 8 kept, 4 dropped, dropped last still ends tile
    clrq();
    go(1'b0, '0);
    start = 1'b1; cfg_rows = 16'd12;
    ob.out_rdy = 1'b0;
    for (int r = 0; r < 12; r++) go(1'b1, rrow(r));
    repeat (8) go(1'b0, '0);
    chk("t3_ovf",  64'(ovf),        64'd1);
    chk("t3_vld",  64'(ob.out_vld), 64'd1);
    chk("t3_busy", 64'(busy),       64'd1);
    ob.out_rdy = 1'b1;
    wait_done("t3_done", 40);
    chk("t3_n", 64'(pd.size()), 64'd8);
    nl = 0;
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("t3_row%0d", r), qd(r), erow(r));
      if (ql(r) === 64'd1) nl++;
    end
    chk("t3_nolast", 64'(nl), 64'd0);

    // FIFO full with simultaneous pop: no drop
    clrq();
    go(1'b0, '0);
    start = 1'b1; cfg_rows = 16'd16;
    ob.out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      go(1'b1, rrow(i));
      ob.out_rdy = (i >= 12);
    end
    chk("t4_ovf", 64'(ovf), 64'd0);
    wait_done("t4_done", 60);
    chk("t4_ovf2", 64'(ovf), 64'd0);
    chk("t4_n", 64'(pd.size()), 64'd16);
    nl = 0;
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("t4_row%0d", r), qd(r), erow(r));
      if (ql(r) === 64'd1) nl++;
    end
    chk("t4_nlast", 64'(nl), 64'd1);
    chk("t4_last15", ql(15), 64'd1);

    // framing: stray in_vld and start are ignored
    clrq();
    go(1'b1, rrow(20));
    start = 1'b1; cfg_rows = 16'd3;
    go(1'b1, rrow(0));
    start = 1'b1; cfg_rows = 16'd9;
    go(1'b1, rrow(1));
    go(1'b1, rrow(2));
    go(1'b1, rrow(3));
    go(1'b1, rrow(4));
    wait_done("t5_done", 40);
    chk("t5_n",     64'(pd.size()), 64'd3);
    chk("t5_r0",    qd(0), erow(0));
    chk("t5_r1",    qd(1), erow(1));
    chk("t5_r2",    qd(2), erow(2));
    chk("t5_last0", ql(0), 64'd0);
    chk("t5_last1", ql(1), 64'd0);
    chk("t5_last2", ql(2), 64'd1);

    // zero-row tile
    go(1'b0, '0);
    start = 1'b1; cfg_rows = 16'd0;
    t0 = cyc;
    wait_done("t6_done", 10);
    chk("t6_lat",  64'(done_cyc - t0), 64'd2);
    chk("t6_busy", 64'(done_busy), 64'd0);

    // reset mid-tile with rows in flight and FIFO full
    clrq();
    go(1'b0, '0);
    start = 1'b1; cfg_rows = 16'd16;
    ob.out_rdy = 1'b0;
    for (int r = 0; r < 14; r++) go(1'b1, rrow(r));
    chk("t7_ovf_pre", 64'(ovf),        64'd1);
    chk("t7_vld_pre", 64'(ob.out_vld), 64'd1);
    go(1'b0, '0);
    rst = 1'b1;
    go(1'b0, '0);
    chk("t7_vld",  64'(ob.out_vld), 64'd0);
    chk("t7_busy", 64'(busy),       64'd0);
    chk("t7_ovf",  64'(ovf),        64'd0);
    rst = 1'b0;
    ob.out_rdy = 1'b1;
    d0 = done_n;
    repeat (10) go(1'b0, '0);
    chk("t7_vld2", 64'(ob.out_vld), 64'd0);
    chk("t7_nout", 64'(pd.size()),  64'd0);
    chk("t7_ndone", 64'(done_n - d0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
